// File: rtl/data_distribute_pkg.sv
// -----------------------------------------------------------------------------
// data_distribute_pkg
// Shared constants for the 1-to-2 stream distributor (data_distribute) and its
// per-channel output register (dist_out_reg).
//   ST_IDLE / ST_LOCK : packet-level state encoding
//   CH_ONE  / CH_TWO  : channel index values carried by the select signals
//   CNT_WIDTH         : width of the optional completed-packet counters
//   cnt_inc           : wrapping increment used by the packet counters
// -----------------------------------------------------------------------------
package data_distribute_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  localparam logic CH_ONE = 1'b0;
  localparam logic CH_TWO = 1'b1;

  localparam int CNT_WIDTH = 16;

  // Plain modular increment: all-ones rolls over to zero.
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return c + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dist_out_reg.sv
// -----------------------------------------------------------------------------
// dist_out_reg
// One-entry registered output stage with a valid/ready handshake. A beat can
// be loaded whenever the slot is empty or is being drained in the same cycle,
// which gives full 1 beat/cycle throughput with no bubble.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : load i_data/i_last this cycle (caller guarantees o_can_take)
//   i_data       : beat data to load
//   i_last       : beat last flag to load
//   i_ready      : downstream consumer ready
//   o_valid      : slot holds a beat
//   o_data       : held beat data
//   o_last       : held beat last flag
//   o_can_take   : slot can accept a beat this cycle (empty or draining)
//   o_pkt_done   : handshake of a beat carrying last (packet completed)
// -----------------------------------------------------------------------------
module dist_out_reg
  import data_distribute_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_can_take,
  output logic                  o_pkt_done
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;

  // Pass-through drain: a beat leaving this cycle frees the slot for a new one.
  assign o_can_take = ~r_valid | i_ready;
  assign o_pkt_done = r_valid & i_ready & r_last;

  // Output stage register: data/last only change on a load, so they hold
  // stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/data_distribute.sv
// -----------------------------------------------------------------------------
// data_distribute
// 1-to-2 stream distributor. Each packet from a single producer is routed to
// channel one or channel two, chosen by in_sel on the packet's first beat and
// locked until its last beat. Each channel has one registered output stage,
// so an accepted beat appears on its channel one cycle later.
//
// Parameters:
//   DATA_WIDTH : width of every data bus
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_data/in_sel/in_last/in_valid : input beat (in_sel used on first beat)
//   in_ready                        : input beat accepted when in_valid & in_ready
//   data_one/last_one/valid_one     : channel one output, ready_one from consumer
//   data_two/last_two/valid_two     : channel two output, ready_two from consumer
//   busy                            : a packet is in progress (LOCK)
// Optional feature (macro DATA_DISTRIBUTE_CNT_EN):
//   cnt_one, cnt_two : wrapping 16-bit counts of packets completed on each
//                      channel (output handshake with last set)
// -----------------------------------------------------------------------------
module data_distribute
  import data_distribute_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_one,
  output logic                  last_one,
  output logic                  valid_one,
  input  logic                  ready_one,
  output logic [DATA_WIDTH-1:0] data_two,
  output logic                  last_two,
  output logic                  valid_two,
  input  logic                  ready_two,
  output logic                  busy
`ifdef DATA_DISTRIBUTE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_one,
  output logic [CNT_WIDTH-1:0]  cnt_two
`endif
);

  logic r_state;
  logic r_lock_sel;

  logic w_eff_sel;
  logic w_can_one;
  logic w_can_two;
  logic w_accept;
  logic w_load_one;
  logic w_load_two;
  logic w_done_one;
  logic w_done_two;

  // Mid-packet the locked channel wins; in_sel only matters on a first beat.
  assign w_eff_sel = (r_state == ST_LOCK) ? r_lock_sel : in_sel;

  // Readiness looks only at the channel this beat would go to, so a stalled
  // other channel never blocks the stream.
  assign in_ready   = (w_eff_sel == CH_TWO) ? w_can_two : w_can_one;
  assign w_accept   = in_valid & in_ready;
  assign w_load_one = w_accept & (w_eff_sel == CH_ONE);
  assign w_load_two = w_accept & (w_eff_sel == CH_TWO);

  // Packet lock: a non-last beat accepted in IDLE captures the channel; the
  // lock is released only by an accepted last beat, however long that takes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= CH_ONE;
    end else if (w_accept) begin
      if (in_last) begin
        r_state <= ST_IDLE;
      end else begin
        r_state    <= ST_LOCK;
        r_lock_sel <= w_eff_sel;
      end
    end
  end

  assign busy = (r_state == ST_LOCK);

  // Output stage, channel one
  dist_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_one (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load_one),
    .i_data     (in_data),
    .i_last     (in_last),
    .i_ready    (ready_one),
    .o_valid    (valid_one),
    .o_data     (data_one),
    .o_last     (last_one),
    .o_can_take (w_can_one),
    .o_pkt_done (w_done_one)
  );

  // Output stage, channel two
  dist_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_two (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load_two),
    .i_data     (in_data),
    .i_last     (in_last),
    .i_ready    (ready_two),
    .o_valid    (valid_two),
    .o_data     (data_two),
    .o_last     (last_two),
    .o_can_take (w_can_two),
    .o_pkt_done (w_done_two)
  );

`ifdef DATA_DISTRIBUTE_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt_one;
  logic [CNT_WIDTH-1:0] r_cnt_two;

  // A packet counts as complete when its last beat leaves the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_one <= '0;
      r_cnt_two <= '0;
    end else begin
      if (w_done_one) r_cnt_one <= cnt_inc(r_cnt_one);
      if (w_done_two) r_cnt_two <= cnt_inc(r_cnt_two);
    end
  end

  assign cnt_one = r_cnt_one;
  assign cnt_two = r_cnt_two;
`else
  // Completion strobes only feed the optional counters.
  logic w_unused_done;
  assign w_unused_done = w_done_one ^ w_done_two;
`endif

endmodule

// File: tb/tb_data_distribute.sv
// -----------------------------------------------------------------------------
// tb_data_distribute
// Self-checking bench for data_distribute: a directed vector table, hand-written
// reset sequences, and a randomized run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_data_distribute;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sel, in_last, in_valid, in_ready;
  logic [DW-1:0] data_one, data_two;
  logic          last_one, valid_one, ready_one;
  logic          last_two, valid_two, ready_two;
  logic          busy;
`ifdef DATA_DISTRIBUTE_CNT_EN
  logic [15:0]   cnt_one, cnt_two;
`endif

  always #5 clk = ~clk;

  data_distribute #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_one  (data_one),
    .last_one  (last_one),
    .valid_one (valid_one),
    .ready_one (ready_one),
    .data_two  (data_two),
    .last_two  (last_two),
    .valid_two (valid_two),
    .ready_two (ready_two),
    .busy      (busy)
`ifdef DATA_DISTRIBUTE_CNT_EN
    ,
    .cnt_one   (cnt_one),
    .cnt_two   (cnt_two)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [DW-1:0] d,
                       input logic r1, input logic r2);
    in_valid  = v;
    in_sel    = s;
    in_last   = l;
    in_data   = d;
    ready_one = r1;
    ready_two = r2;
  endtask

  // Advance one clock; inputs were set at the falling edge, outputs are
  // observed at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Directed vectors: inputs held for one cycle, expected in_ready before the
  // edge and expected outputs after it. Data/last only checked while valid.
  typedef struct {
    logic          v, s, l;
    logic [DW-1:0] d;
    logic          r1, r2;
    logic          e_rdy;
    logic          e_v1;
    logic [DW-1:0] e_d1;
    logic          e_l1;
    logic          e_v2;
    logic [DW-1:0] e_d2;
    logic          e_l2;
    logic          e_busy;
  } vec_t;

  vec_t tbl [17];

  // Reference model: each channel is a queue of {last,data} beats waiting to
  // be consumed; a packet in progress pins the destination channel.
  logic [DW:0] q1[$];
  logic [DW:0] q2[$];
  bit          m_busy;
  bit          m_sel;
  int          m_pk1, m_pk2;

  function automatic bit model_ready(input bit s, input bit r1, input bit r2);
    bit dest;
    dest = m_busy ? m_sel : s;
    if (dest) return (q2.size() == 0) || r2;
    return (q1.size() == 0) || r1;
  endfunction

  task automatic model_step(input bit v, input bit s, input bit l, input logic [DW-1:0] d,
                            input bit r1, input bit r2);
    bit dest, acc;
    logic [DW:0] b;
    dest = m_busy ? m_sel : s;
    acc  = v && model_ready(s, r1, r2);
    if (r1 && q1.size() > 0) begin b = q1.pop_front(); if (b[DW]) m_pk1++; end
    if (r2 && q2.size() > 0) begin b = q2.pop_front(); if (b[DW]) m_pk2++; end
    if (acc) begin
      if (dest) q2.push_back({l, d}); else q1.push_back({l, d});
      if (l) m_busy = 0;
      else begin m_busy = 1; m_sel = dest; end
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_busy = 0;
    m_sel  = 0;
    m_pk1  = 0;
    m_pk2  = 0;
  endtask

  initial begin
    //             v s l d     r1 r2 rdy v1 d1    l1 v2 d2    l2 busy
    tbl[0]  = '{1,1,1,4'hA, 1,1, 1, 0,4'h0,0, 1,4'hA,1, 0}; // single-beat to ch2
    tbl[1]  = '{1,0,0,4'h5, 1,1, 1, 1,4'h5,0, 0,4'h0,0, 1}; // lock ch1
    tbl[2]  = '{1,1,0,4'h6, 1,1, 1, 1,4'h6,0, 0,4'h0,0, 1}; // in_sel ignored
    tbl[3]  = '{1,1,1,4'h7, 1,1, 1, 1,4'h7,1, 0,4'h0,0, 0}; // last -> idle
    tbl[4]  = '{0,0,0,4'h0, 0,1, 0, 1,4'h7,1, 0,4'h0,0, 0}; // ch1 stalled
    tbl[5]  = '{1,0,0,4'h3, 0,1, 0, 1,4'h7,1, 0,4'h0,0, 0}; // ch1 beat blocked
    tbl[6]  = '{1,0,0,4'h3, 0,1, 0, 1,4'h7,1, 0,4'h0,0, 0};
    tbl[7]  = '{1,1,1,4'hC, 0,1, 1, 1,4'h7,1, 1,4'hC,1, 0}; // ch2 still flows
    tbl[8]  = '{1,0,0,4'h3, 0,0, 0, 1,4'h7,1, 1,4'hC,1, 0};
    tbl[9]  = '{1,0,0,4'h3, 1,1, 1, 1,4'h3,0, 0,4'h0,0, 1}; // release, b2b
    tbl[10] = '{1,0,0,4'h4, 1,1, 1, 1,4'h4,0, 0,4'h0,0, 1};
    tbl[11] = '{1,1,1,4'h5, 1,1, 1, 1,4'h5,1, 0,4'h0,0, 0};
    tbl[12] = '{0,0,0,4'h0, 1,1, 1, 0,4'h0,0, 0,4'h0,0, 0};
    tbl[13] = '{1,1,0,4'h9, 1,1, 1, 0,4'h0,0, 1,4'h9,0, 1}; // lock ch2
    tbl[14] = '{0,0,0,4'h0, 1,0, 0, 0,4'h0,0, 1,4'h9,0, 1}; // lock ignores free ch1
    tbl[15] = '{1,0,1,4'hE, 1,1, 1, 0,4'h0,0, 1,4'hE,1, 0};
    tbl[16] = '{0,0,0,4'h0, 1,1, 1, 0,4'h0,0, 0,4'h0,0, 0};

    // Reset while the producer is already offering a beat.
    rst = 1'b1;
    drive(1, 0, 1, 4'hF, 1, 1);
    tick();
    tick();
    chk("rst_valid_one", valid_one, 0);
    chk("rst_valid_two", valid_two, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_one", data_one, 0);
    chk("rst_data_two", data_two, 0);
    chk("rst_last_one", last_one, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid_one", valid_one, 1);
    chk("post_rst_data_one", data_one, 4'hF);
    chk("post_rst_busy", busy, 0);
    drive(0, 0, 0, 4'h0, 1, 1);
    tick();
    chk("post_rst_drained", valid_one, 0);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      tick();
      chk($sformatf("tbl%0d_valid_one", i), valid_one, tbl[i].e_v1);
      chk($sformatf("tbl%0d_valid_two", i), valid_two, tbl[i].e_v2);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_v1) begin
        chk($sformatf("tbl%0d_data_one", i), data_one, tbl[i].e_d1);
        chk($sformatf("tbl%0d_last_one", i), last_one, tbl[i].e_l1);
      end
      if (tbl[i].e_v2) begin
        chk($sformatf("tbl%0d_data_two", i), data_two, tbl[i].e_d2);
        chk($sformatf("tbl%0d_last_two", i), last_two, tbl[i].e_l2);
      end
    end

    // Reset in the middle of a 4-beat packet bound for channel one, with the
    // consumer stalled so a beat is still held when reset hits.
    drive(1, 0, 0, 4'h1, 0, 1);
    tick();
    drive(1, 0, 0, 4'h2, 1, 1);
    tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 0, 0);
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid_one", valid_one, 0);
    chk("mid_rst_valid_two", valid_two, 0);
    rst = 1'b0;
    drive(1, 1, 1, 4'hB, 0, 1);
    #1;
    chk("mid_new_in_ready", in_ready, 1);
    tick();
    chk("mid_new_valid_two", valid_two, 1);
    chk("mid_new_data_two", data_two, 4'hB);
    chk("mid_new_valid_one", valid_one, 0);
    drive(0, 0, 0, 4'h0, 1, 1);
    tick();

`ifdef DATA_DISTRIBUTE_CNT_EN
    // Packet counters: three packets to channel one, one to channel two.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 0, 1, 4'h1, 1, 1); tick();
    drive(1, 0, 0, 4'h2, 1, 1); tick();
    drive(1, 1, 1, 4'h3, 1, 1); tick();
    drive(1, 1, 1, 4'h4, 1, 1); tick();
    drive(1, 0, 1, 4'h5, 1, 1); tick();
    drive(0, 0, 0, 4'h0, 1, 1); tick();
    tick();
    chk("cnt_one_dir", cnt_one, 3);
    chk("cnt_two_dir", cnt_two, 1);
`endif

    // Randomized run against the reference model.
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 1, 1);
    tick();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit v, s, l, r1, r2;
      logic [DW-1:0] d;
      chk("rnd_valid_one", valid_one, q1.size() > 0);
      chk("rnd_valid_two", valid_two, q2.size() > 0);
      chk("rnd_busy", busy, m_busy);
      if (q1.size() > 0) chk("rnd_beat_one", {last_one, data_one}, q1[0]);
      if (q2.size() > 0) chk("rnd_beat_two", {last_two, data_two}, q2[0]);
      v  = ($urandom_range(0, 3) != 0);
      s  = $urandom_range(0, 1);
      l  = ($urandom_range(0, 3) == 0);
      d  = DW'($urandom);
      r1 = ($urandom_range(0, 2) != 0);
      r2 = ($urandom_range(0, 2) != 0);
      drive(v, s, l, d, r1, r2);
      #1;
      chk("rnd_in_ready", in_ready, model_ready(s, r1, r2));
      model_step(v, s, l, d, r1, r2);
      tick();
    end
`ifdef DATA_DISTRIBUTE_CNT_EN
    chk("rnd_cnt_one", cnt_one, 16'(m_pk1));
    chk("rnd_cnt_two", cnt_two, 16'(m_pk2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_distribute.md
Name: data_distribute

Overview:
- 1-to-2 stream distributor: routes an input data stream to one of two output channels (`data_one`, `data_two`), selected per packet.
- Reverse counterpart of the 2:1 data selector; sits between a single producer and two consumers.
- Valid/ready handshake on all sides; one registered output stage per channel.
- Channel choice is locked for the duration of a packet.

Parameters:
- DATA_WIDTH, 4, width of every data bus.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  DATA_WIDTH  input beat data
- in_sel  input  1  channel select: 0 → channel one, 1 → channel two; meaningful only on the first beat of a packet
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- data_one  output  DATA_WIDTH  channel one data
- last_one  output  1  channel one last flag
- valid_one  output  1  channel one valid
- ready_one  input  1  channel one consumer ready
- data_two  output  DATA_WIDTH  channel two data
- last_two  output  1  channel two last flag
- valid_two  output  1  channel two valid
- ready_two  input  1  channel two consumer ready
- busy  output  1  high while a packet is in progress (state LOCK)

Behaviour:
- Reset (rst high at a clock edge):
  - valid_one, valid_two, busy ← 0.
  - data_* and last_* ← 0.
  - State ← IDLE; locked select ← 0.
  - Reset mid-packet abandons the packet, including any held beats.
- Per-channel output register, one entry each. Channel k can take a beat when valid_k == 0 or ready_k == 1 in the same cycle (pass-through drain).
- Effective select:
  - In IDLE it is in_sel.
  - In LOCK it is the locked select register; in_sel is ignored.
- in_ready is combinational: the effective-select channel can take a beat. It never depends on the non-selected channel.
- Accepted beat:
  - Loaded into the selected channel register at the next edge; valid_k goes high one cycle after acceptance.
  - Latency is 1 cycle; sustained throughput is 1 beat/cycle when ready_k stays high.
- Drain: valid_k clears on the edge where valid_k & ready_k, unless a new beat loads in the same cycle, in which case valid_k stays high with the new data.
- Output data and last hold stable while valid_k & ~ready_k (no change without a handshake).
- State machine:
  - IDLE, accepted beat with in_last=0 → LOCK; locked select ← in_sel.
  - IDLE, accepted beat with in_last=1 → IDLE (single-beat packet).
  - LOCK, accepted beat with in_last=1 → IDLE.
  - No accepted beat → stay in the current state.
- busy = (state == LOCK).
- Both channels may drain in the same cycle independently. Channel two can drain while a packet streams to channel one.
- in_valid may drop mid-packet; the lock is held indefinitely until the last beat.

Optional Feature:
- Macro: DATA_DISTRIBUTE_CNT_EN.
- When defined:
  - Adds outputs cnt_one and cnt_two, each 16 bits.
  - Each counts completed packets (output handshake with last_k=1) on its channel.
  - Counters wrap from 16'hFFFF to 0 and are cleared by rst.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `data_distribute_pkg`:
  - State encoding constants ST_IDLE=1'b0, ST_LOCK=1'b1.
  - Channel index constants CH_ONE=1'b0, CH_TWO=1'b1.
  - Counter width constant CNT_WIDTH=16.
- Sub-module `dist_out_reg`: the one-entry output register with valid/ready, parameterized by DATA_WIDTH. Instantiated twice.

Test Plan:
- Reset with in_valid=1: all valid_*, busy, data_* = 0 during rst. After rst release, the first accepted beat appears 1 cycle later.
- Single-beat packet: in_sel=1, in_last=1, in_data=4'hA, ready_two=1 → next cycle valid_two=1, data_two=4'hA, last_two=1. busy stays 0; channel one untouched.
- Lock: packet of 3 beats (5, 6, 7), in_sel=0 on beat 1 and in_sel=1 on beats 2–3 → all three beats on channel one, last_one on 7. busy high from after beat 1 until after beat 3.
- Backpressure: ready_one=0 for 4 cycles with valid_one=1 → data_one held stable. in_ready=0 for channel-one traffic while channel-two traffic is still accepted when idle. On ready_one=1, back-to-back beats at 1/cycle.
- Reset mid-packet: after beat 2 of a 4-beat packet, assert rst → busy=0, valid_*=0. The next packet with in_sel=1 routes to channel two.
- With DATA_DISTRIBUTE_CNT_EN: send 3 packets to channel one and 1 to channel two → cnt_one=3, cnt_two=1. Preload via 65536 packets → cnt_one wraps to 0.
